// File: rtl/chacha20_pkg.sv
// chacha20_pkg
//   Shared constants, types and helpers for the ChaCha20 block core:
//   sigma constants, the 16x32-bit state type, the core state enum,
//   the quarter-round index tables for column/diagonal rounds, a 32-bit
//   rotate helper and the initial-state builder.
package chacha20_pkg;

   localparam logic [31:0] SIGMA0 = 32'h6170_7865;
   localparam logic [31:0] SIGMA1 = 32'h3320_646e;
   localparam logic [31:0] SIGMA2 = 32'h7962_2d32;
   localparam logic [31:0] SIGMA3 = 32'h6b20_6574;

   typedef logic [31:0] word_t;

   // Element i occupies bits [32*i+31:32*i], which is exactly the
   // keystream word layout, so the work bank can drive ks_data directly.
   typedef logic [15:0][31:0] state_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROUND  = 2'd1,
      ST_FINAL  = 2'd2,
      ST_OUTPUT = 2'd3
   } core_state_t;

   // Slot {qr, lane}: qr selects one of the four quarter-round instances,
   // lane selects its a/b/c/d operand. Entry = state word index.
   // Column:   (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15)
   localparam logic [15:0][3:0] QR_COL_IDX = {
      4'd15, 4'd11, 4'd7,  4'd3,
      4'd14, 4'd10, 4'd6,  4'd2,
      4'd13, 4'd9,  4'd5,  4'd1,
      4'd12, 4'd8,  4'd4,  4'd0
   };

   // Diagonal: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14)
   localparam logic [15:0][3:0] QR_DIAG_IDX = {
      4'd14, 4'd9,  4'd4,  4'd3,
      4'd13, 4'd8,  4'd7,  4'd2,
      4'd12, 4'd11, 4'd6,  4'd1,
      4'd15, 4'd10, 4'd5,  4'd0
   };

   function automatic logic [3:0] qr_index(input logic diag,
                                           input logic [1:0] qr,
                                           input logic [1:0] lane);
      logic [3:0] slot;
      slot = {qr, lane};
      if (diag) begin
         return QR_DIAG_IDX[slot];
      end else begin
         return QR_COL_IDX[slot];
      end
   endfunction

   // Rotate left by n (1..31); (0 - n) mod 32 is the matching right shift.
   function automatic word_t rotl32(input word_t x, input logic [4:0] n);
      return (x << n) | (x >> (5'd0 - n));
   endfunction

   function automatic state_t init_state(input logic [255:0] key,
                                         input logic [95:0]  nonce,
                                         input logic [31:0]  counter);
      state_t s;
      s     = 512'd0;
      s[0]  = SIGMA0;
      s[1]  = SIGMA1;
      s[2]  = SIGMA2;
      s[3]  = SIGMA3;
      for (int i = 0; i < 8; i++) begin
         s[4 + i] = key[32*i +: 32];
      end
      s[12] = counter;
      for (int j = 0; j < 3; j++) begin
         s[13 + j] = nonce[32*j +: 32];
      end
      return s;
   endfunction

endpackage

// File: rtl/chacha20_quarter_round.sv
// chacha20_quarter_round
//   Purely combinational ChaCha20 quarter round on four 32-bit words.
// Ports:
//   a, b, c, d                  in  32  operand words
//   a_new, b_new, c_new, d_new  out 32  quarter-round result
module chacha20_quarter_round
   import chacha20_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   output logic [31:0] a_new,
   output logic [31:0] b_new,
   output logic [31:0] c_new,
   output logic [31:0] d_new
);

   logic [31:0] a1_s, b1_s, c1_s, d1_s;
   logic [31:0] a2_s, b2_s, c2_s, d2_s;

   // Two add-xor-rotate half steps: rotations 16/12 then 8/7.
   always_comb begin
      a1_s = a + b;
      d1_s = rotl32(d ^ a1_s, 5'd16);
      c1_s = c + d1_s;
      b1_s = rotl32(b ^ c1_s, 5'd12);
      a2_s = a1_s + b1_s;
      d2_s = rotl32(d1_s ^ a2_s, 5'd8);
      c2_s = c1_s + d2_s;
      b2_s = rotl32(b1_s ^ c2_s, 5'd7);
   end

   assign a_new = a2_s;
   assign b_new = b2_s;
   assign c_new = c2_s;
   assign d_new = d2_s;

endmodule

// File: rtl/chacha20_block_core.sv
// chacha20_block_core
//   Iterative ChaCha20 block function: one round per cycle, then the final
//   feed-forward add, then a valid/ready hand-off of the 512-bit block.
//   Drives freeze to the upstream block counter so it advances exactly once
//   per delivered block (in the handshake cycle).
// Ports:
//   clk       in   1    clock
//   rst       in   1    asynchronous active-low reset
//   key       in   256  key, word i -> state word 4+i
//   nonce     in   96   nonce, word j -> state word 13+j
//   counter   in   32   block counter -> state word 12
//   start     in   1    request one block (honoured only in IDLE)
//   busy      out  1    high in ROUND, FINAL and OUTPUT
//   freeze    out  1    ~(ks_valid & ks_ready), holds the counter stage
//   ks_data   out  512  keystream block, word i at [32*i+31:32*i]
//   ks_valid  out  1    ks_data valid
//   ks_ready  in   1    downstream accepts ks_data
module chacha20_block_core
   import chacha20_pkg::*;
#(
   parameter int ROUNDS = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] key,
   input  logic [95:0]  nonce,
   input  logic [31:0]  counter,
   input  logic         start,
   output logic         busy,
   output logic         freeze,
   output logic [511:0] ks_data,
   output logic         ks_valid,
   input  logic         ks_ready
);

   localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

   core_state_t state_r, state_next_s;
   logic [4:0]  round_r, round_next_s;
   state_t      init_r, init_next_s;
   state_t      work_r, work_next_s;
   logic        busy_r;
   logic        ks_valid_r;

   logic        diag_s;
   state_t      round_state_s;
   word_t       qa_s [4];
   word_t       qb_s [4];
   word_t       qc_s [4];
   word_t       qd_s [4];
   word_t       qa_new_s [4];
   word_t       qb_new_s [4];
   word_t       qc_new_s [4];
   word_t       qd_new_s [4];

   // Odd round indices are diagonal rounds, even ones column rounds.
   assign diag_s = round_r[0];

   // Route the four operand words of each quarter round out of the work bank.
   always_comb begin
      for (int q = 0; q < 4; q++) begin
         qa_s[q] = work_r[qr_index(diag_s, 2'(q), 2'd0)];
         qb_s[q] = work_r[qr_index(diag_s, 2'(q), 2'd1)];
         qc_s[q] = work_r[qr_index(diag_s, 2'(q), 2'd2)];
         qd_s[q] = work_r[qr_index(diag_s, 2'(q), 2'd3)];
      end
   end

   // The four quarter rounds of one round touch disjoint words, so they run
   // side by side on shared instances for both round types.
   for (genvar g = 0; g < 4; g++) begin : g_qr
      chacha20_quarter_round u_qr (
         .a     (qa_s[g]),
         .b     (qb_s[g]),
         .c     (qc_s[g]),
         .d     (qd_s[g]),
         .a_new (qa_new_s[g]),
         .b_new (qb_new_s[g]),
         .c_new (qc_new_s[g]),
         .d_new (qd_new_s[g])
      );
   end

   // Scatter the quarter-round results back into their state positions.
   always_comb begin
      round_state_s = work_r;
      for (int q = 0; q < 4; q++) begin
         round_state_s[qr_index(diag_s, 2'(q), 2'd0)] = qa_new_s[q];
         round_state_s[qr_index(diag_s, 2'(q), 2'd1)] = qb_new_s[q];
         round_state_s[qr_index(diag_s, 2'(q), 2'd2)] = qc_new_s[q];
         round_state_s[qr_index(diag_s, 2'(q), 2'd3)] = qd_new_s[q];
      end
   end

   // Next-state and datapath control for IDLE -> ROUND -> FINAL -> OUTPUT.
   always_comb begin
      state_next_s = state_r;
      round_next_s = round_r;
      init_next_s  = init_r;
      work_next_s  = work_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               init_next_s  = init_state(key, nonce, counter);
               work_next_s  = init_state(key, nonce, counter);
               round_next_s = 5'd0;
               state_next_s = ST_ROUND;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ROUND: begin
            work_next_s  = round_state_s;
            round_next_s = round_r + 5'd1;
            if (round_r == LAST_ROUND) begin
               state_next_s = ST_FINAL;
            end else begin
               state_next_s = ST_ROUND;
            end
         end
         ST_FINAL: begin
            for (int i = 0; i < 16; i++) begin
               work_next_s[i] = work_r[i] + init_r[i];
            end
            state_next_s = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            // start is deliberately not looked at here, even on the
            // handshake cycle; a new request must arrive in IDLE.
            if (ks_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_OUTPUT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State, round index, register banks and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         round_r    <= 5'd0;
         init_r     <= 512'd0;
         work_r     <= 512'd0;
         busy_r     <= 1'b0;
         ks_valid_r <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         round_r    <= round_next_s;
         init_r     <= init_next_s;
         work_r     <= work_next_s;
         busy_r     <= (state_next_s != ST_IDLE);
         ks_valid_r <= (state_next_s == ST_OUTPUT);
      end
   end

   // The work bank holds the finished block from FINAL until the handshake.
   assign ks_data  = work_r;
   assign ks_valid = ks_valid_r;
   assign busy     = busy_r;
   assign freeze   = ~(ks_valid_r & ks_ready);

endmodule

// File: tb/tb_chacha20_block_core.sv
// Scoreboard bench for chacha20_block_core with a behavioural ChaCha20
// reference model and a model of the upstream block counter stage.
module tb_chacha20_block_core;

   localparam int N_ROUNDS = 20;

   logic         clk;
   logic         rst;
   logic [255:0] key;
   logic [95:0]  nonce;
   logic [31:0]  ctr;
   logic         start;
   logic         busy;
   logic         freeze;
   logic [511:0] ks_data;
   logic         ks_valid;
   logic         ks_ready;

   logic         ctr_load;
   logic [31:0]  ctr_load_val;

   logic [31:0]  qa, qb, qc, qd, qa_o, qb_o, qc_o, qd_o;

   typedef struct {
      logic [511:0] data;
      bit           rfc;
   } exp_t;

   exp_t         exp_q [$];
   int           n_checks;
   int           n_errors;
   logic [31:0]  exp_ctr;
   logic [255:0] rfc_key;
   logic [95:0]  rfc_nonce;

   chacha20_block_core #(.ROUNDS(N_ROUNDS)) dut (
      .clk      (clk),
      .rst      (rst),
      .key      (key),
      .nonce    (nonce),
      .counter  (ctr),
      .start    (start),
      .busy     (busy),
      .freeze   (freeze),
      .ks_data  (ks_data),
      .ks_valid (ks_valid),
      .ks_ready (ks_ready)
   );

   chacha20_quarter_round u_qr (
      .a (qa), .b (qb), .c (qc), .d (qd),
      .a_new (qa_o), .b_new (qb_o), .c_new (qc_o), .d_new (qd_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream counter stage: advances whenever freeze is low.
   always @(posedge clk or negedge rst) begin
      if (!rst)          ctr <= 32'd1;
      else if (ctr_load) ctr <= ctr_load_val;
      else if (!freeze)  ctr <= ctr + 32'd1;
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] rol(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [127:0] m_qr(input logic [31:0] a, b, c, d);
      a = a + b; d = rol(d ^ a, 16);
      c = c + d; b = rol(b ^ c, 12);
      a = a + b; d = rol(d ^ a, 8);
      c = c + d; b = rol(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
      logic [31:0]  s [16];
      logic [31:0]  x [16];
      logic [511:0] o;
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
      s[12] = c;
      for (int j = 0; j < 3; j++) s[13 + j] = n[32*j +: 32];
      for (int i = 0; i < 16; i++) x[i] = s[i];
      for (int r = 0; r < N_ROUNDS; r += 2) begin
         {x[0], x[4], x[8],  x[12]} = m_qr(x[0], x[4], x[8],  x[12]);
         {x[1], x[5], x[9],  x[13]} = m_qr(x[1], x[5], x[9],  x[13]);
         {x[2], x[6], x[10], x[14]} = m_qr(x[2], x[6], x[10], x[14]);
         {x[3], x[7], x[11], x[15]} = m_qr(x[3], x[7], x[11], x[15]);
         {x[0], x[5], x[10], x[15]} = m_qr(x[0], x[5], x[10], x[15]);
         {x[1], x[6], x[11], x[12]} = m_qr(x[1], x[6], x[11], x[12]);
         {x[2], x[7], x[8],  x[13]} = m_qr(x[2], x[7], x[8],  x[13]);
         {x[3], x[4], x[9],  x[14]} = m_qr(x[3], x[4], x[9],  x[14]);
      end
      for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
      return o;
   endfunction

   function automatic logic [255:0] rand_key();
      logic [255:0] k;
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
      return k;
   endfunction

   function automatic logic [95:0] rand_nonce();
      logic [95:0] n;
      for (int i = 0; i < 3; i++) n[32*i +: 32] = $urandom();
      return n;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   initial begin
      int           cyc, start_cyc, freeze_lows;
      bit           tracking, seen_valid, hold;
      logic [511:0] hold_data;
      exp_t         e;
      cyc = 0; start_cyc = 0; freeze_lows = 0;
      tracking = 0; seen_valid = 0; hold = 0; hold_data = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            tracking = 0; seen_valid = 0; hold = 0;
         end else begin
            check("freeze_eq", {511'd0, freeze}, {511'd0, ~(ks_valid & ks_ready)});
            if (!freeze) freeze_lows++;
            if (hold) begin
               check("hold_valid", {511'd0, ks_valid}, 512'd1);
               check("hold_data", ks_data, hold_data);
            end
            if (ks_valid && !seen_valid && tracking) begin
               check("latency", 512'(cyc - start_cyc - 1), 512'(N_ROUNDS + 1));
               seen_valid = 1;
            end
            if (ks_valid) check("busy_in_output", {511'd0, busy}, 512'd1);
            if (ks_valid && ks_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_errors++;
                  $display("FAIL unexpected_block: got %0h, required none", ks_data);
               end else begin
                  e = exp_q.pop_front();
                  check("ks_data", ks_data, e.data);
                  check("freeze_pulses", 512'(freeze_lows), 512'd1);
                  if (e.rfc) begin
                     check("rfc_w0",  512'(ks_data[31:0]),    512'(32'he4e7f110));
                     check("rfc_w1",  512'(ks_data[63:32]),   512'(32'h15593bd1));
                     check("rfc_w15", 512'(ks_data[511:480]), 512'(32'h4e3c50a2));
                  end
               end
               tracking = 0;
            end
            hold      = ks_valid && !ks_ready;
            hold_data = ks_data;
            if (start && !busy) begin
               tracking = 1; start_cyc = cyc; freeze_lows = 0; seen_valid = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // rmode: 0 ready always 1, 1 random ready, 2 ready low for 10 valid cycles.
   task automatic do_block(input logic [255:0] k, input logic [95:0] n,
                           input int rmode, input bit noise, input bit rfc);
      int guard, vcnt;
      guard = 0;
      while (busy && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      if (busy) begin
         n_checks++; n_errors++;
         $display("FAIL idle_timeout: got busy=1, required busy=0");
      end
      key = k; nonce = n; start = 1'b1;
      exp_q.push_back('{data: ref_block(k, n, exp_ctr), rfc: rfc});
      exp_ctr = exp_ctr + 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0; vcnt = 0;
      while (busy && guard < 200) begin
         if (noise) begin
            start = 1'($urandom_range(0, 1));
            key   = rand_key();
            nonce = rand_nonce();
         end
         case (rmode)
            0:       ks_ready = 1'b1;
            1:       ks_ready = 1'($urandom_range(0, 1));
            default: ks_ready = (vcnt >= 10);
         endcase
         if (ks_valid) vcnt++;
         @(posedge clk); #1; guard++;
      end
      start = 1'b0;
      if (busy) begin
         n_checks++; n_errors++;
         $display("FAIL block_timeout: got busy=1 after %0d cycles, required busy=0", guard);
      end
   endtask

   task automatic load_ctr(input logic [31:0] v);
      ctr_load = 1'b1; ctr_load_val = v;
      @(posedge clk); #1;
      ctr_load = 1'b0;
      exp_ctr  = v;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ks_valid"}, {511'd0, ks_valid}, 512'd0);
      check({tag, "_busy"},     {511'd0, busy},     512'd0);
      check({tag, "_freeze"},   {511'd0, freeze},   512'd1);
      check({tag, "_ks_data"},  ks_data,            512'd0);
   endtask

   initial begin
      logic [511:0] rb;
      n_checks = 0; n_errors = 0;
      rst = 1'b0; start = 1'b0; ks_ready = 1'b0; key = '0; nonce = '0;
      ctr_load = 1'b0; ctr_load_val = 32'd0; exp_ctr = 32'd1;
      for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
      rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

      // Quarter round vector on a standalone instance.
      qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
      #1;
      check("qr_a", 512'(qa_o), 512'(32'hea2a92f4));
      check("qr_b", 512'(qb_o), 512'(32'hcb1cf8ce));
      check("qr_c", 512'(qc_o), 512'(32'h4581472e));
      check("qr_d", 512'(qd_o), 512'(32'h5881c4bb));

      // Reference model against the published block vector.
      rb = ref_block(rfc_key, rfc_nonce, 32'd1);
      check("model_w0",  512'(rb[31:0]),    512'(32'he4e7f110));
      check("model_w15", 512'(rb[511:480]), 512'(32'h4e3c50a2));

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("rst_release");

      // RFC block, counter 1 from the counter stage reset value.
      do_block(rfc_key, rfc_nonce, 0, 1'b0, 1'b1);

      // Back-pressure.
      do_block(rand_key(), rand_nonce(), 2, 1'b0, 1'b0);

      // Three back-to-back requests with counters 1, 2, 3.
      load_ctr(32'd1);
      for (int i = 0; i < 3; i++) do_block(rfc_key, rfc_nonce, 0, 1'b0, (i == 0));

      // Reset during round index 7, then a clean RFC block.
      key = rfc_key; nonce = rfc_nonce; start = 1'b1;
      exp_q.push_back('{data: ref_block(rfc_key, rfc_nonce, exp_ctr), rfc: 1'b0});
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_abort");
      void'(exp_q.pop_back());
      exp_ctr = 32'd1;
      @(posedge clk); #1;
      rst = 1'b1;
      do_block(rfc_key, rfc_nonce, 0, 1'b0, 1'b1);

      // start pulses and key/nonce changes while busy, random back-pressure.
      for (int i = 0; i < 3; i++) do_block(rand_key(), rand_nonce(), 1, 1'b1, 1'b0);

      // Counter 0xFFFFFFFF used as-is; the stage then wraps to 0.
      load_ctr(32'hFFFFFFFF);
      do_block(rand_key(), rand_nonce(), 0, 1'b0, 1'b0);
      do_block(rand_key(), rand_nonce(), 1, 1'b0, 1'b0);

      // Random blocks.
      for (int i = 0; i < 4; i++) do_block(rand_key(), rand_nonce(), 1, 1'b0, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", 512'(exp_q.size()), 512'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
